// File: rtl/gbprocessor_stim_pkg.sv
// Shared types and helpers for the gbprocessor instruction-stream generator.
// The LFSR helper works on a 32-bit container; callers zero-extend narrower words.
package gbprocessor_stim_pkg;

    typedef enum logic [1:0] {
        SWEEP  = 2'd0,
        LFSR   = 2'd1,
        REPEAT = 2'd2,
        RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
    localparam int         LFSR_MAX_W    = 32;

    // Galois right shift: the bit shifted out selects whether the taps are folded in.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] value,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (value >> 1) ^ (value[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/gbprocessor_stim_gen.sv
// Configurable instruction-stream source for gbprocessor bring-up: sweep, LFSR or
// constant repeat, with programmable length, idle gaps, backpressure and abort.
module gbprocessor_stim_gen
    import gbprocessor_stim_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 8,
    parameter int                     COUNT_WIDTH = 16,
    parameter int                     GAP_WIDTH   = 4,
    parameter logic [INSTR_WIDTH-1:0] LFSR_TAPS   = INSTR_WIDTH'(LFSR_TAPS_DEF),
    parameter logic [INSTR_WIDTH-1:0] LFSR_SEED   = INSTR_WIDTH'(LFSR_SEED_DEF)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [INSTR_WIDTH-1:0] first_instr,
    input  logic [INSTR_WIDTH-1:0] step,
    input  logic [COUNT_WIDTH-1:0] num_instr,
    input  logic [GAP_WIDTH-1:0]   gap,
    input  logic                   ready,
    input  logic                   abort,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] issued_count,
    output logic                   err
);

    state_t                 state_q;
    mode_t                  mode_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [INSTR_WIDTH-1:0] step_q;
    logic [COUNT_WIDTH-1:0] num_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [GAP_WIDTH-1:0]   gap_cnt_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic                   transfer;
    logic                   last_xfer;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [INSTR_WIDTH-1:0] next_instr_d;
    logic [INSTR_WIDTH-1:0] start_instr_d;

    assign transfer  = valid_q & ready;
    assign count_d   = count_q + COUNT_WIDTH'(1);
    assign last_xfer = (count_d == num_q);

    always_comb begin
        next_instr_d = instr_q;
        unique case (mode_q)
            SWEEP:   next_instr_d = instr_q + step_q;
            LFSR:    next_instr_d = INSTR_WIDTH'(lfsr_next(LFSR_MAX_W'(instr_q),
                                                           LFSR_MAX_W'(LFSR_TAPS)));
            default: next_instr_d = instr_q;
        endcase
    end

    // An all-zero LFSR state would lock up, so a zero seed is swapped for LFSR_SEED.
    always_comb begin
        start_instr_d = first_instr;
        if (mode_t'(mode) == LFSR && first_instr == '0) begin
            start_instr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= SWEEP;
            instr_q   <= '0;
            step_q    <= '0;
            num_q     <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        if (mode_t'(mode) == RSVD) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= mode_t'(mode);
                            step_q  <= step;
                            num_q   <= num_instr;
                            gap_q   <= gap;
                            err_q   <= 1'b0;
                            count_q <= '0;
                            if (num_instr == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ISSUE;
                                instr_q <= start_instr_d;
                                valid_q <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (transfer) begin
                        count_q <= count_d;
                    end
                    if (abort || (transfer && last_xfer)) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (transfer) begin
                        instr_q <= next_instr_d;
                        if (gap_q != '0) begin
                            state_q   <= GAP;
                            valid_q   <= 1'b0;
                            gap_cnt_q <= gap_q;
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign instruction  = instr_q;
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = count_q;
    assign err          = err_q;

endmodule

// File: doc/gbprocessor_stim_gen.md
Name: gbprocessor_stim_gen

Overview:
Synthesisable instruction-stream generator for gbprocessor bring-up, replacing the fixed behavioural 0x00..0xFF sweep with a parametrised, configurable source. It drives `instruction`/`valid` toward the gbprocessor interface and supports three modes: arithmetic sweep, LFSR pseudo-random and constant repeat. It adds programmable length, inter-instruction gaps, downstream backpressure, abort, and a done/count report. It sits between the test top (or an on-chip debug controller) and the DUT instruction port.

Parameters:
INSTR_WIDTH, 8, instruction word width
COUNT_WIDTH, 16, width of the length and issued counters
GAP_WIDTH, 4, width of the idle-gap field
LFSR_TAPS, 8'hB8, Galois LFSR tap mask, INSTR_WIDTH bits
LFSR_SEED, 8'hA5, substitute seed used when a zero seed is supplied

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
mode  in  2  0 SWEEP, 1 LFSR, 2 REPEAT, 3 reserved
first_instr  in  INSTR_WIDTH  first instruction (SWEEP/REPEAT) or LFSR seed
step  in  INSTR_WIDTH  SWEEP increment
num_instr  in  COUNT_WIDTH  number of instructions to issue
gap  in  GAP_WIDTH  idle cycles between transfers
ready  in  1  downstream accept
abort  in  1  terminate the run early
instruction  out  INSTR_WIDTH  current instruction
valid  out  1  instruction is valid
busy  out  1  run in progress
done  out  1  one-cycle end-of-run pulse
issued_count  out  COUNT_WIDTH  number of transfers in the current or last run
err  out  1  sticky illegal-mode flag

Behaviour:
- Single clock domain `clock`. `reset` is asynchronous and active-high.
- Reset values: instruction=0, valid=0, busy=0, done=0, issued_count=0, err=0, state=IDLE. Asserting reset mid-run returns everything to these values immediately; no done pulse is produced.
- States: IDLE, ISSUE, GAP, DONE.
- IDLE, start=1, mode=3: set err=1 and stay in IDLE.
- IDLE, start=1, mode!=3: latch mode, step, num_instr and gap; clear err and issued_count.
  - num_instr=0: go to DONE.
  - Otherwise go to ISSUE. instruction=first_instr; in LFSR mode a zero seed is replaced by LFSR_SEED. valid rises the cycle after start is sampled.
- ISSUE: valid=1 and busy=1. A transfer is valid&&ready. instruction and valid stay stable while valid&&!ready.
- On a transfer, issued_count increments.
  - If this was the num_instr-th transfer: go to DONE; valid=0 the next cycle.
  - Otherwise compute the next value. SWEEP: instr+step, modulo 2^INSTR_WIDTH (wraps). LFSR: Galois right shift; if the old LSB is 1, XOR with LFSR_TAPS. REPEAT: value unchanged.
  - gap=0: stay in ISSUE; the next value is valid the next cycle (back-to-back transfers).
  - gap>0: go to GAP with the counter loaded to gap; valid=0.
- GAP: busy=1, valid=0. The counter decrements each cycle; at 1, go to ISSUE with the next value. This gives exactly `gap` idle cycles.
- abort in ISSUE or GAP: go to DONE. A transfer in the same cycle is still counted. valid=0 the next cycle. abort in IDLE or DONE is ignored.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. issued_count holds until the next accepted start.
- start while busy: ignored.
- issued_count never exceeds num_instr.

Decomposition:
- Package gbprocessor_stim_pkg holds:
  - mode_t enum: SWEEP, LFSR, REPEAT, RSVD.
  - state_t enum: IDLE, ISSUE, GAP, DONE.
  - Default LFSR_TAPS and LFSR_SEED constants.
  - Pure function lfsr_next(value, taps).
- No sub-module. The FSM, counters and next-value mux live in one module.

Test Plan:
1. Full sweep: mode=0, first=0x00, step=1, num=256, gap=0, ready=1 -> instructions 0x00..0xFF on 256 consecutive cycles starting one cycle after start; done pulses the cycle after the 0xFF transfer; issued_count=256.
2. Wrap: mode=0, first=0xFE, step=3, num=4 -> 0xFE, 0x01, 0x04, 0x07; then done.
3. LFSR with zero seed: mode=1, first=0x00, num=4 -> 0xA5, 0xEA, 0x75, 0x82.
4. Backpressure and gap: mode=0, first=0x10, step=1, num=3, gap=2; ready low for the first 3 valid cycles -> 0x10 held 4 cycles, 2 idle cycles, 0x11, 2 idle cycles, 0x12; issued_count=3.
5. Edge cases:
   - num=0 -> done one cycle after start; valid never rises.
   - mode=3 -> err=1, busy stays 0.
   - abort during GAP after 2 transfers -> done next cycle, issued_count=2.
6. Asynchronous reset mid-ISSUE (between clock edges) -> valid, busy and instruction go to 0 immediately, no done pulse; a new start afterwards runs normally.
